// File: rtl/rv_instr_encoder.sv
// Purpose : encodes RV32I instruction descriptors into 32-bit words and writes them
//           in sequence into instruction memory. Illegal or out-of-range
//           descriptors are rejected and reported.
// Latency : handshake at edge N, then ENC at cycle N+1, then write or error at cycle N+2.
//           Throughput is one descriptor every 3 cycles.
// Backpressure: in_ready is high only in IDLE, when not full and when clear is low.
//
// Ports:
//   clk, reset (sync, active-high), clear (sync pointer reset and abort)
//   in_valid/in_ready handshake plus descriptor fields:
//     in_class, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm
//   mem_we/mem_addr/mem_wdata : imem write port
//   count/full                : words written since reset or clear
//   err/err_code              : reject pulse; the code is held until the next reject
module rv_instr_encoder #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic [1:0]        err_code
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ENC  = 2'd1,
        S_WR   = 2'd2
    } state_t;

    localparam logic [2:0] C_LW    = 3'd0;
    localparam logic [2:0] C_SW    = 3'd1;
    localparam logic [2:0] C_RTYPE = 3'd2;
    localparam logic [2:0] C_ITYPE = 3'd3;
    localparam logic [2:0] C_BEQ   = 3'd4;
    localparam logic [2:0] C_JAL   = 3'd5;

    localparam logic [1:0] E_NONE  = 2'b00;
    localparam logic [1:0] E_ILL   = 2'b01;
    localparam logic [1:0] E_RANGE = 2'b10;
    localparam logic [1:0] E_ALIGN = 2'b11;

    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

    state_t state_q, state_d;

    // Descriptor fields captured at the handshake.
    logic [2:0]         cls_q;
    logic [2:0]         f3_q;
    logic               f7_q;
    logic [4:0]         rd_q;
    logic [4:0]         rs1_q;
    logic [4:0]         rs2_q;
    logic signed [31:0] imm_q;

    // Encoded word and verdict, registered at the end of ENC.
    logic [31:0] word_q, word_c;
    logic [1:0]  code_q, code_c;

    logic [1:0]      err_code_q;
    logic [ADDR_W:0] count_q;

    logic accept;
    logic abort;
    logic illegal, range_bad, misaligned;
    logic imm12_ok, imm13_ok, imm21_ok;

    assign abort    = reset || clear;
    assign full     = (count_q == DEPTH_C);
    assign in_ready = (state_q == S_IDLE) && !full && !abort;
    assign accept   = in_valid && in_ready;

    // Next-state logic. clear forces IDLE. reset is handled in the register.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = S_ENC;
            S_ENC:   state_d = S_WR;
            S_WR:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (clear) state_d = S_IDLE;
    end

    // Immediate range windows. B and J offsets are byte offsets of even size.
    assign imm12_ok = (imm_q >= -32'sd2048)    && (imm_q <= 32'sd2047);
    assign imm13_ok = (imm_q >= -32'sd4096)    && (imm_q <= 32'sd4094);
    assign imm21_ok = (imm_q >= -32'sd1048576) && (imm_q <= 32'sd1048574);

    // Encode and classify the latched descriptor.
    always_comb begin
        word_c     = 32'h0;
        illegal    = 1'b0;
        range_bad  = 1'b0;
        misaligned = 1'b0;

        // funct7 bit 5 is meaningful only for sub.
        if (f7_q && !(cls_q == C_RTYPE && f3_q == 3'b000)) illegal = 1'b1;

        unique case (cls_q)
            C_LW: begin
                word_c    = {imm_q[11:0], rs1_q, 3'b010, rd_q, 7'b0000011};
                range_bad = !imm12_ok;
            end
            C_SW: begin
                word_c    = {imm_q[11:5], rs2_q, rs1_q, 3'b010, imm_q[4:0], 7'b0100011};
                range_bad = !imm12_ok;
            end
            C_RTYPE: begin
                // Bit 30 is set only for sub. The shift, compare and logic ops clear it.
                word_c = {1'b0, f7_q & (f3_q == 3'b000), 5'b0, rs2_q, rs1_q, f3_q, rd_q,
                          7'b0110011};
                if (!(f3_q inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111})) illegal = 1'b1;
            end
            C_ITYPE: begin
                word_c    = {imm_q[11:0], rs1_q, f3_q, rd_q, 7'b0010011};
                range_bad = !imm12_ok;
                if (!(f3_q inside {3'b000, 3'b010, 3'b110, 3'b111})) illegal = 1'b1;
            end
            C_BEQ: begin
                word_c     = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, 3'b000, imm_q[4:1],
                              imm_q[11], 7'b1100011};
                range_bad  = !imm13_ok;
                misaligned = imm_q[0];
            end
            C_JAL: begin
                word_c     = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q,
                              7'b1101111};
                range_bad  = !imm21_ok;
                misaligned = imm_q[0];
            end
            default: illegal = 1'b1;
        endcase

        // An illegal class or funct wins over a range error, which wins over misalignment.
        if (illegal)         code_c = E_ILL;
        else if (range_bad)  code_c = E_RANGE;
        else if (misaligned) code_c = E_ALIGN;
        else                 code_c = E_NONE;
    end

    // The write or error in WR is suppressed in the cycle that reset or clear is asserted,
    // so an aborted descriptor leaves no trace.
    assign mem_we    = (state_q == S_WR) && (code_q == E_NONE) && !abort;
    assign err       = (state_q == S_WR) && (code_q != E_NONE) && !abort;
    assign mem_addr  = count_q[ADDR_W-1:0];
    assign mem_wdata = mem_we ? word_q : 32'h0;
    assign err_code  = err ? code_q : err_code_q;
    assign count     = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cls_q      <= 3'd0;
            f3_q       <= 3'd0;
            f7_q       <= 1'b0;
            rd_q       <= 5'd0;
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
            imm_q      <= 32'sd0;
            word_q     <= 32'h0;
            code_q     <= E_NONE;
            err_code_q <= E_NONE;
            count_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cls_q <= in_class;
                f3_q  <= in_funct3;
                f7_q  <= in_funct7b5;
                rd_q  <= in_rd;
                rs1_q <= in_rs1;
                rs2_q <= in_rs2;
                imm_q <= in_imm;
            end
            if (state_q == S_ENC) begin
                word_q <= word_c;
                code_q <= code_c;
            end
            if (err) err_code_q <= code_q;
            if (clear)       count_q <= '0;
            else if (mem_we) count_q <= count_q + ONE_C;
        end
    end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed-vector bench for rv_instr_encoder. The expected words are worked out by hand.
module tb_rv_instr_encoder;

    logic        clk = 1'b0;
    logic        reset, clear, in_valid, in_ready;
    logic [2:0]  in_class, in_funct3;
    logic        in_funct7b5;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        mem_we, full, err;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [6:0]  count;
    logic [1:0]  err_code;

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt = 0;
    logic [1:0] exp_ec = 2'b00;

    rv_instr_encoder #(.ADDR_W(6), .DEPTH(64)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .full(full), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Called at a negedge. Waits a bounded time for in_ready, then performs one handshake.
    task automatic send(input logic [2:0] cls, input logic [2:0] f3, input logic f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
        int t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("rdy_wait", {31'b0, in_ready}, 32'd1);
        in_class = cls; in_funct3 = f3; in_funct7b5 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Sends one descriptor and checks the ENC cycle, the WR cycle and the count afterwards.
    // An exp_code of 00 means a legal descriptor.
    task automatic run_one(input string tag, input logic [2:0] cls, input logic [2:0] f3,
                           input logic f7, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm,
                           input logic [31:0] exp_word, input logic [1:0] exp_code);
        send(cls, f3, f7, rd, rs1, rs2, imm);
        @(negedge clk);
        chk({tag, "_enc_rdy"}, {31'b0, in_ready}, 32'd0);
        chk({tag, "_enc_we"}, {31'b0, mem_we}, 32'd0);
        @(negedge clk);
        if (exp_code == 2'b00) begin
            chk({tag, "_we"}, {31'b0, mem_we}, 32'd1);
            chk({tag, "_addr"}, {26'b0, mem_addr}, exp_cnt[31:0] & 32'h3F);
            chk({tag, "_wdata"}, mem_wdata, exp_word);
            chk({tag, "_err"}, {31'b0, err}, 32'd0);
            exp_cnt++;
        end else begin
            chk({tag, "_we"}, {31'b0, mem_we}, 32'd0);
            chk({tag, "_err"}, {31'b0, err}, 32'd1);
            chk({tag, "_code"}, {30'b0, err_code}, {30'b0, exp_code});
            exp_ec = exp_code;
        end
        @(negedge clk);
        chk({tag, "_cnt"}, {25'b0, count}, exp_cnt[31:0]);
        if (exp_code != 2'b00)
            chk({tag, "_held"}, {30'b0, err_code}, {30'b0, exp_code});
    endtask

    // Sends a descriptor, then aborts it with clear or reset during ENC or WR.
    task automatic abort_case(input string tag, input bit use_rst, input bit in_wr,
                              input logic [2:0] cls, input logic [31:0] imm);
        send(cls, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, imm);
        @(negedge clk);
        if (in_wr) @(negedge clk);
        if (use_rst) reset = 1'b1; else clear = 1'b1;
        #1;
        chk({tag, "_we"}, {31'b0, mem_we}, 32'd0);
        chk({tag, "_err"}, {31'b0, err}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0; clear = 1'b0;
        exp_cnt = 0;
        if (use_rst) exp_ec = 2'b00;
        @(negedge clk);
        chk({tag, "_idle"}, {31'b0, in_ready}, 32'd1);
        chk({tag, "_cnt"}, {25'b0, count}, 32'd0);
        chk({tag, "_ec"}, {30'b0, err_code}, {30'b0, exp_ec});
        repeat (2) begin
            @(negedge clk);
            chk({tag, "_quiet"}, {30'b0, mem_we, err}, 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0;
        in_class = 3'd0; in_funct3 = 3'd0; in_funct7b5 = 1'b0;
        in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", {31'b0, in_ready}, 32'd0);
        chk("rst_outs", {mem_we, full, err, err_code, 1'b0, count, mem_addr}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        #1 chk("post_rst_rdy", {31'b0, in_ready}, 32'd1);

        // Basic words, issued back to back.
        run_one("add",  3'd2, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0,  32'h002081B3, 2'b00);
        run_one("sub",  3'd2, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0,  32'h402081B3, 2'b00);
        run_one("lw",   3'd0, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, -32'sd4, 32'hFFC02283, 2'b00);
        run_one("sw",   3'd1, 3'b000, 1'b0, 5'd0, 5'd2, 5'd5, 32'd8,  32'h00512423, 2'b00);
        run_one("beq",  3'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd8, 32'hFE208CE3, 2'b00);
        run_one("jal",  3'd5, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h001000EF, 2'b00);
        run_one("addi", 3'd3, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, -32'sd1, 32'hFFF00093, 2'b00);
        run_one("andi", 3'd3, 3'b111, 1'b0, 5'd2, 5'd1, 5'd0, 32'd2047, 32'h7FF0F113, 2'b00);
        run_one("beqmx", 3'd4, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd4094, 32'h7E000FE3, 2'b00);
        run_one("jalmn", 3'd5, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFF00000, 32'h8000006F, 2'b00);

        // Rejected descriptors.
        run_one("e_beq3",  3'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3,    32'd0, 2'b11);
        run_one("e_addi",  3'd3, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'd0, 2'b10);
        run_one("e_cls7",  3'd7, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0,    32'd0, 2'b01);
        run_one("e_if3",   3'd3, 3'b001, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0,    32'd0, 2'b01);
        run_one("e_beqrg", 3'd4, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd4096, 32'd0, 2'b10);
        run_one("e_beqpr", 3'd4, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd4095, 32'd0, 2'b10);
        run_one("e_jalrg", 3'd5, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd1048576, 32'd0, 2'b10);
        run_one("e_sltf7", 3'd2, 3'b010, 1'b1, 5'd1, 5'd0, 5'd0, 32'd0,    32'd0, 2'b01);
        run_one("e_rf3",   3'd2, 3'b011, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0,    32'd0, 2'b01);
        run_one("e_cls6",  3'd6, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5000, 32'd0, 2'b01);

        // When clear and in_valid are asserted together, no handshake may happen.
        in_valid = 1'b1; clear = 1'b1;
        #1 chk("clr_vld_rdy", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0; clear = 1'b0;
        exp_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            chk("clr_vld_quiet", {30'b0, mem_we, err}, 32'd0);
        end
        chk("clr_vld_cnt", {25'b0, count}, 32'd0);
        chk("clr_vld_ec", {30'b0, err_code}, {30'b0, exp_ec});

        // Fill memory to DEPTH.
        for (int i = 0; i < 64; i++)
            run_one("fill", 3'd3, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, i, {i[11:0], 20'h00093}, 2'b00);
        chk("full", {31'b0, full}, 32'd1);
        chk("full_rdy", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("full_no_we", {31'b0, mem_we}, 32'd0);
        end
        in_valid = 1'b0;
        chk("full_cnt", {25'b0, count}, 32'd64);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        chk("clr_cnt", {25'b0, count}, 32'd0);
        chk("clr_full", {31'b0, full}, 32'd0);
        run_one("after_clr", 3'd2, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 2'b00);

        // Aborts in ENC and in WR, using clear and then reset.
        abort_case("clr_enc", 1'b0, 1'b0, 3'd3, 32'd1);
        abort_case("clr_wr",  1'b0, 1'b1, 3'd7, 32'd0);
        run_one("pre_rst", 3'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd1, 32'd0, 2'b11);
        abort_case("rst_enc", 1'b1, 1'b0, 3'd3, 32'd1);
        abort_case("rst_wr",  1'b1, 1'b1, 3'd3, 32'd2);
        run_one("final", 3'd0, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, -32'sd4, 32'hFFC02283, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
